// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared sizes and types for the issue scoreboard
package issue_scoreboard_pkg;

   localparam int NREG  = 32;
   localparam int IDX_W = 5;
   localparam int CNT_W = 2;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [IDX_W-1:0] reg_idx_t;

   localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/pending_counter_bank.sv
// rtl/pending_counter_bank.sv - per-register pending-write counters for one register file
module pending_counter_bank
   import issue_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc_en,
   input  reg_idx_t        inc_idx,
   input  logic            dec_en,
   input  reg_idx_t        dec_idx,
   input  logic            flush,
   input  reg_idx_t        lookup_idx,
   output logic            at_max,
   output logic [NREG-1:0] busy,
   output logic            err
);

   cnt_t cnt [NREG];

   // Count issues up and retires down; a matching issue/retire pair cancels, flush clears everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (flush) begin
               cnt[i] <= '0;
            end else if (inc_en && inc_idx == reg_idx_t'(i) &&
                         !(dec_en && dec_idx == reg_idx_t'(i))) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (dec_en && dec_idx == reg_idx_t'(i) &&
                         !(inc_en && inc_idx == reg_idx_t'(i)) && cnt[i] != '0) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   // A register is busy while any write to it is still in flight
   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++) begin
         busy[i] = (cnt[i] != '0);
      end
   end

   assign at_max = (cnt[lookup_idx] == CNT_MAX);

   // Retiring a register with nothing outstanding is a back-end protocol error
   assign err = dec_en && !flush && (cnt[dec_idx] == '0) &&
                !(inc_en && inc_idx == dec_idx);

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - decode-to-backend issue gate with pending-write tracking
module issue_scoreboard
   import issue_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic            dec_halt,
   input  logic            r_read1,
   input  logic            r_read2,
   input  logic            v_read1,
   input  logic            v_read2,
   input  reg_idx_t        scalar_read_register1,
   input  reg_idx_t        scalar_read_register2,
   input  reg_idx_t        vector_read_register1,
   input  reg_idx_t        vector_read_register2,
   input  logic            register_wr_en,
   input  reg_idx_t        scalar_write_register,
   input  logic            vector_wr_en,
   input  reg_idx_t        vector_write_register,
   input  logic            wb_s_en,
   input  reg_idx_t        wb_s_idx,
   input  logic            wb_v_en,
   input  reg_idx_t        wb_v_idx,
   input  logic            flush,
   output logic [NREG-1:0] scalar_busy,
   output logic [NREG-1:0] vector_busy,
   output logic            idle,
   output logic            halted,
   output logic            sb_err
);

   logic issue;
   logic s_at_max;
   logic v_at_max;
   logic s_err;
   logic v_err;

   pending_counter_bank u_scalar_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_en     (issue && register_wr_en),
      .inc_idx    (scalar_write_register),
      .dec_en     (wb_s_en),
      .dec_idx    (wb_s_idx),
      .flush      (flush),
      .lookup_idx (scalar_write_register),
      .at_max     (s_at_max),
      .busy       (scalar_busy),
      .err        (s_err)
   );

   pending_counter_bank u_vector_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_en     (issue && vector_wr_en),
      .inc_idx    (vector_write_register),
      .dec_en     (wb_v_en),
      .dec_idx    (wb_v_idx),
      .flush      (flush),
      .lookup_idx (vector_write_register),
      .at_max     (v_at_max),
      .busy       (vector_busy),
      .err        (v_err)
   );

   // Ready looks only at registered counters, so a same-cycle retire never bypasses into issue
   always_comb begin
      dec_ready = !halted && !flush;
      if (r_read1 && scalar_busy[scalar_read_register1]) dec_ready = 1'b0;
      if (r_read2 && scalar_busy[scalar_read_register2]) dec_ready = 1'b0;
      if (v_read1 && vector_busy[vector_read_register1]) dec_ready = 1'b0;
      if (v_read2 && vector_busy[vector_read_register2]) dec_ready = 1'b0;
      if (register_wr_en && s_at_max)                    dec_ready = 1'b0;
      if (vector_wr_en && v_at_max)                      dec_ready = 1'b0;
   end

   assign issue = dec_valid && dec_ready;
   assign idle  = ~|{scalar_busy, vector_busy};

   // Halt and error flags are sticky until reset; flush leaves both alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
         sb_err <= 1'b0;
      end else begin
         if (issue && dec_halt) halted <= 1'b1;
         if (s_err || v_err)    sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - randomized self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid, dec_ready, dec_halt;
   logic        r_read1, r_read2, v_read1, v_read2;
   logic [4:0]  scalar_read_register1, scalar_read_register2;
   logic [4:0]  vector_read_register1, vector_read_register2;
   logic        register_wr_en, vector_wr_en;
   logic [4:0]  scalar_write_register, vector_write_register;
   logic        wb_s_en, wb_v_en;
   logic [4:0]  wb_s_idx, wb_v_idx;
   logic        flush;
   logic [31:0] scalar_busy, vector_busy;
   logic        idle, halted, sb_err;

   int n_pass  = 0;
   int n_total = 0;

   int sc [32];
   int vc [32];
   bit m_halted;
   bit m_err;

   always #5 clk = ~clk;

   issue_scoreboard dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .dec_valid             (dec_valid),
      .dec_ready             (dec_ready),
      .dec_halt              (dec_halt),
      .r_read1               (r_read1),
      .r_read2               (r_read2),
      .v_read1               (v_read1),
      .v_read2               (v_read2),
      .scalar_read_register1 (scalar_read_register1),
      .scalar_read_register2 (scalar_read_register2),
      .vector_read_register1 (vector_read_register1),
      .vector_read_register2 (vector_read_register2),
      .register_wr_en        (register_wr_en),
      .scalar_write_register (scalar_write_register),
      .vector_wr_en          (vector_wr_en),
      .vector_write_register (vector_write_register),
      .wb_s_en               (wb_s_en),
      .wb_s_idx              (wb_s_idx),
      .wb_v_en               (wb_v_en),
      .wb_v_idx              (wb_v_idx),
      .flush                 (flush),
      .scalar_busy           (scalar_busy),
      .vector_busy           (vector_busy),
      .idle                  (idle),
      .halted                (halted),
      .sb_err                (sb_err)
   );

   task automatic clear_inputs();
      dec_valid = 0; dec_halt = 0;
      r_read1 = 0; r_read2 = 0; v_read1 = 0; v_read2 = 0;
      scalar_read_register1 = 0; scalar_read_register2 = 0;
      vector_read_register1 = 0; vector_read_register2 = 0;
      register_wr_en = 0; scalar_write_register = 0;
      vector_wr_en = 0; vector_write_register = 0;
      wb_s_en = 0; wb_s_idx = 0; wb_v_en = 0; wb_v_idx = 0;
      flush = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         sc[i] = 0;
         vc[i] = 0;
      end
      m_halted = 0;
      m_err = 0;
   endtask

   function automatic bit model_ready();
      if (m_halted || flush) return 0;
      if (r_read1 && sc[scalar_read_register1] != 0) return 0;
      if (r_read2 && sc[scalar_read_register2] != 0) return 0;
      if (v_read1 && vc[vector_read_register1] != 0) return 0;
      if (v_read2 && vc[vector_read_register2] != 0) return 0;
      if (register_wr_en && sc[scalar_write_register] == 3) return 0;
      if (vector_wr_en && vc[vector_write_register] == 3) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] model_busy(input bit vec);
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = vec ? (vc[i] != 0) : (sc[i] != 0);
      return b;
   endfunction

   function automatic bit model_idle();
      return (model_busy(0) == 0) && (model_busy(1) == 0);
   endfunction

   // Advance one clock with the current inputs and apply the same transaction to the model.
   task automatic step();
      bit iss;
      int s_inc, v_inc;
      iss = dec_valid && model_ready();
      @(posedge clk);
      if (flush) begin
         for (int i = 0; i < 32; i++) begin
            sc[i] = 0;
            vc[i] = 0;
         end
      end else begin
         s_inc = (iss && register_wr_en) ? int'(scalar_write_register) : -1;
         v_inc = (iss && vector_wr_en) ? int'(vector_write_register) : -1;
         if (s_inc >= 0) sc[s_inc]++;
         if (wb_s_en) begin
            if (sc[wb_s_idx] == 0) m_err = 1;
            else sc[wb_s_idx]--;
         end
         if (v_inc >= 0) vc[v_inc]++;
         if (wb_v_en) begin
            if (vc[wb_v_idx] == 0) m_err = 1;
            else vc[wb_v_idx]--;
         end
      end
      if (iss && dec_halt) m_halted = 1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      model_reset();
      rst_n = 0;
      #3;
      n_total++;
      if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle); else n_pass++;
      n_total++;
      if ({scalar_busy, vector_busy} !== 64'h0) $display("FAIL reset_busy got %h exp 0", {scalar_busy, vector_busy}); else n_pass++;
      n_total++;
      if ({halted, sb_err, dec_ready} !== 3'b001) $display("FAIL reset_flags got %b exp 001", {halted, sb_err, dec_ready}); else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic test_raw();
      clear_inputs();
      dec_valid = 1; register_wr_en = 1; scalar_write_register = 5;
      #1;
      n_total++;
      if (dec_ready !== 1'b1) $display("FAIL raw_writer_ready got %b exp 1", dec_ready); else n_pass++;
      step();
      clear_inputs();
      dec_valid = 1; r_read1 = 1; scalar_read_register1 = 5;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_total++;
         if (dec_ready !== 1'b0) $display("FAIL raw_blocked got %b exp 0", dec_ready); else n_pass++;
         step();
      end
      wb_s_en = 1; wb_s_idx = 5;
      #1;
      n_total++;
      if (dec_ready !== 1'b0) $display("FAIL raw_no_bypass got %b exp 0", dec_ready); else n_pass++;
      step();
      wb_s_en = 0;
      #1;
      n_total++;
      if (dec_ready !== 1'b1) $display("FAIL raw_released got %b exp 1", dec_ready); else n_pass++;
      step();
      clear_inputs();
      #1;
      n_total++;
      if (idle !== model_idle()) $display("FAIL raw_idle got %b exp %b", idle, model_idle()); else n_pass++;
   endtask

   task automatic test_saturation();
      clear_inputs();
      dec_valid = 1; vector_wr_en = 1; vector_write_register = 2;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_total++;
         if (dec_ready !== 1'b1) $display("FAIL sat_write%0d got %b exp 1", k, dec_ready); else n_pass++;
         step();
      end
      n_total++;
      if (vector_busy[2] !== 1'b1) $display("FAIL sat_busy got %b exp 1", vector_busy[2]); else n_pass++;
      #1;
      n_total++;
      if (dec_ready !== 1'b0) $display("FAIL sat_fourth got %b exp 0", dec_ready); else n_pass++;
      wb_v_en = 1; wb_v_idx = 2;
      #1;
      n_total++;
      if (dec_ready !== 1'b0) $display("FAIL sat_no_bypass got %b exp 0", dec_ready); else n_pass++;
      step();
      wb_v_en = 0;
      #1;
      n_total++;
      if (dec_ready !== 1'b1) $display("FAIL sat_after_retire got %b exp 1", dec_ready); else n_pass++;
      step();
      clear_inputs();
      wb_v_en = 1; wb_v_idx = 2;
      for (int k = 0; k < 3; k++) step();
      clear_inputs();
      #1;
      n_total++;
      if ({idle, sb_err} !== 2'b10) $display("FAIL sat_drain got %b exp 10", {idle, sb_err}); else n_pass++;
   endtask

   task automatic test_simultaneous();
      clear_inputs();
      dec_valid = 1; register_wr_en = 1; scalar_write_register = 7;
      step();
      wb_s_en = 1; wb_s_idx = 7;
      #1;
      n_total++;
      if (dec_ready !== 1'b1) $display("FAIL simul_ready got %b exp 1", dec_ready); else n_pass++;
      step();
      clear_inputs();
      #1;
      n_total++;
      if ({scalar_busy[7], sb_err} !== 2'b10) $display("FAIL simul_state got %b exp 10", {scalar_busy[7], sb_err}); else n_pass++;
      wb_s_en = 1; wb_s_idx = 7;
      step();
      clear_inputs();
      #1;
      n_total++;
      if ({idle, sb_err} !== 2'b10) $display("FAIL simul_single_left got %b exp 10", {idle, sb_err}); else n_pass++;
   endtask

   task automatic test_dual_dest();
      clear_inputs();
      dec_valid = 1;
      register_wr_en = 1; scalar_write_register = 3;
      vector_wr_en = 1; vector_write_register = 4;
      step();
      clear_inputs();
      #1;
      n_total++;
      if ({scalar_busy[3], vector_busy[4], idle} !== 3'b110) $display("FAIL dual_busy got %b exp 110", {scalar_busy[3], vector_busy[4], idle}); else n_pass++;
      wb_s_en = 1; wb_s_idx = 3;
      step();
      clear_inputs();
      #1;
      n_total++;
      if ({scalar_busy[3], vector_busy[4], idle} !== 3'b010) $display("FAIL dual_s_retired got %b exp 010", {scalar_busy[3], vector_busy[4], idle}); else n_pass++;
      wb_v_en = 1; wb_v_idx = 4;
      step();
      clear_inputs();
      #1;
      n_total++;
      if (idle !== 1'b1) $display("FAIL dual_idle got %b exp 1", idle); else n_pass++;
   endtask

   task automatic test_random();
      int idx;
      for (int c = 0; c < 400; c++) begin
         clear_inputs();
         dec_valid = $urandom_range(3) != 0;
         r_read1 = $urandom_range(2) == 0; scalar_read_register1 = 5'($urandom_range(31));
         r_read2 = $urandom_range(3) == 0; scalar_read_register2 = 5'($urandom_range(31));
         v_read1 = $urandom_range(2) == 0; vector_read_register1 = 5'($urandom_range(31));
         v_read2 = $urandom_range(3) == 0; vector_read_register2 = 5'($urandom_range(31));
         register_wr_en = $urandom_range(1); scalar_write_register = 5'($urandom_range(7));
         vector_wr_en = $urandom_range(1); vector_write_register = 5'($urandom_range(7));
         idx = $urandom_range(7);
         wb_s_en = (sc[idx] != 0) && ($urandom_range(2) != 0); wb_s_idx = 5'(idx);
         idx = $urandom_range(7);
         wb_v_en = (vc[idx] != 0) && ($urandom_range(2) != 0); wb_v_idx = 5'(idx);
         flush = $urandom_range(40) == 0;
         #1;
         n_total++;
         if (dec_ready !== model_ready()) $display("FAIL rand_ready c=%0d got %b exp %b", c, dec_ready, model_ready()); else n_pass++;
         n_total++;
         if (scalar_busy !== model_busy(0) || vector_busy !== model_busy(1))
            $display("FAIL rand_busy c=%0d got %h_%h exp %h_%h", c, scalar_busy, vector_busy, model_busy(0), model_busy(1));
         else n_pass++;
         n_total++;
         if ({idle, sb_err} !== {model_idle(), m_err}) $display("FAIL rand_flags c=%0d got %b exp %b", c, {idle, sb_err}, {model_idle(), m_err}); else n_pass++;
         step();
      end
      clear_inputs();
      flush = 1;
      step();
      clear_inputs();
   endtask

   task automatic test_halt_flush();
      clear_inputs();
      dec_valid = 1; register_wr_en = 1; scalar_write_register = 1;
      step();
      clear_inputs();
      dec_valid = 1; dec_halt = 1;
      #1;
      n_total++;
      if (dec_ready !== 1'b1) $display("FAIL halt_issue_ready got %b exp 1", dec_ready); else n_pass++;
      step();
      clear_inputs();
      dec_valid = 1;
      #1;
      n_total++;
      if ({halted, dec_ready} !== 2'b10) $display("FAIL halt_blocks got %b exp 10", {halted, dec_ready}); else n_pass++;
      flush = 1;
      step();
      clear_inputs();
      #1;
      n_total++;
      if ({scalar_busy, vector_busy} !== 64'h0) $display("FAIL flush_busy got %h exp 0", {scalar_busy, vector_busy}); else n_pass++;
      n_total++;
      if ({halted, sb_err, dec_ready} !== 3'b100) $display("FAIL flush_keeps_halt got %b exp 100", {halted, sb_err, dec_ready}); else n_pass++;
      wb_s_en = 1; wb_s_idx = 9;
      step();
      clear_inputs();
      #1;
      n_total++;
      if (sb_err !== m_err || sb_err !== 1'b1) $display("FAIL spurious_wb_err got %b exp 1", sb_err); else n_pass++;
   endtask

   task automatic test_async_reset();
      clear_inputs();
      rst_n = 0;
      step();
      rst_n = 1;
      model_reset();
      dec_valid = 1; register_wr_en = 1; scalar_write_register = 2;
      vector_wr_en = 1; vector_write_register = 6;
      step();
      scalar_write_register = 10;
      step();
      clear_inputs();
      dec_valid = 1; dec_halt = 1;
      step();
      clear_inputs();
      wb_v_en = 1; wb_v_idx = 30;
      step();
      clear_inputs();
      #1;
      n_total++;
      if ({scalar_busy[2], scalar_busy[10], vector_busy[6], halted, sb_err, idle} !== 6'b111110)
         $display("FAIL pre_reset_state got %b exp 111110", {scalar_busy[2], scalar_busy[10], vector_busy[6], halted, sb_err, idle});
      else n_pass++;
      #1;
      rst_n = 0;
      #1;
      model_reset();
      n_total++;
      if ({scalar_busy, vector_busy} !== 64'h0) $display("FAIL async_busy got %h exp 0", {scalar_busy, vector_busy}); else n_pass++;
      n_total++;
      if ({idle, halted, sb_err, dec_ready} !== 4'b1001) $display("FAIL async_flags got %b exp 1001", {idle, halted, sb_err, dec_ready}); else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_raw();
      test_saturation();
      test_simultaneous();
      test_dual_dest();
      test_random();
      test_halt_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Sits directly downstream of the instruction decoder, between decode and the execute/memory back end.
- Per-register pending-write counters for the 32 scalar and 32 vector registers.
- Blocks issue of a decoded instruction while any source it reads, or a destination counter it would increment, is unsafe.
- Back-end writeback ports retire pending writes; also handles halt latching and pipeline flush.

Parameters:
- NREG, 32, registers per file (scalar and vector).
- IDX_W, 5, register index width.
- CNT_W, 2, pending counter width; at most 2^CNT_W-1 in-flight writes per register.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- dec_valid  input  1  decoder presents an instruction.
- dec_ready  output  1  scoreboard accepts it this cycle; issue = dec_valid & dec_ready.
- dec_halt  input  1  instruction is halt.
- r_read1, r_read2  input  1 each  scalar source enables.
- v_read1, v_read2  input  1 each  vector source enables.
- scalar_read_register1/2  input  IDX_W each  scalar source indices.
- vector_read_register1/2  input  IDX_W each  vector source indices.
- register_wr_en  input  1  scalar destination valid.
- scalar_write_register  input  IDX_W  scalar destination; link-writing jumps present 31.
- vector_wr_en  input  1  vector destination valid.
- vector_write_register  input  IDX_W  vector destination.
- wb_s_en / wb_s_idx  input  1 / IDX_W  scalar writeback retire.
- wb_v_en / wb_v_idx  input  1 / IDX_W  vector writeback retire.
- flush  input  1  back end squashed all in-flight instructions.
- scalar_busy  output  NREG  bit i = scalar counter i nonzero.
- vector_busy  output  NREG  bit i = vector counter i nonzero.
- idle  output  1  all counters zero.
- halted  output  1  halt issued (sticky).
- sb_err  output  1  sticky; writeback to a zero counter.

Behaviour:
- Reset (async, rst_n low):
  - all counters 0, halted 0, sb_err 0.
  - hence scalar_busy 0, vector_busy 0, idle 1, dec_ready 1 if no other block.
- dec_ready is combinational from registered state and current inputs. It is 1 iff all of:
  - !halted and !flush.
  - no enabled source has a nonzero counter. Enables: r_read1/2 check scalar, v_read1/2 check vector.
  - if register_wr_en, scalar counter[dest] != max.
  - if vector_wr_en, vector counter[dest] != max.
  - Disabled sources/destinations are never checked.
- No writeback bypass: a retire in cycle t unblocks issue in cycle t+1 at earliest.
- On issue: scalar counter[dest] +1 if register_wr_en; vector counter[dest] +1 if vector_wr_en. Both may fire in one instruction.
- A destination that is also a source is blocked only by the source check.
- wb_s_en: scalar counter[wb_s_idx] -1. wb_v_en likewise for vector. Both ports may fire together.
- Same register incremented by issue and decremented by writeback in one cycle: counter unchanged.
- Writeback to a zero counter: counter stays 0, sb_err set, sticky until reset.
- Issue with dec_halt: halted set next cycle. Thereafter dec_ready=0 until reset; writebacks still retire.
- flush:
  - dec_ready=0 that cycle.
  - next cycle all counters are 0, overriding same-cycle issue and writeback; no sb_err from those writebacks.
  - halted is not cleared.
- Counters never wrap: the increment is blocked at max by the ready rule.
- idle is registered-state derived: the OR-reduction of busy, inverted.

Decomposition:
- Shared package holds:
  - NREG, IDX_W, CNT_W defaults.
  - typedef cnt_t (CNT_W bits).
  - typedef reg_idx_t (IDX_W bits).
- Natural sub-module: pending_counter_bank, instantiated twice (scalar, vector).
  - Bank ports: issue enable/index, retire enable/index, flush, busy vector, counter-at-max lookup, err pulse.
- Top handles the ready logic, halt flag and sb_err.

Test Plan:
- RAW: issue an instruction writing scalar r5, then present a reader of r5 (r_read1=1, index 5).
  - dec_ready=0 until wb_s_en idx 5 is pulsed; dec_ready=1 the following cycle.
- Saturation: issue 3 writes to vector v2 with no writeback.
  - vector_busy[2]=1; the 4th write to v2 has dec_ready=0.
  - One wb_v_en idx 2 lets it issue next cycle.
- Simultaneous: counter s7=1, issue a write to s7 together with wb_s_en idx 7.
  - counter stays 1, scalar_busy[7]=1, sb_err=0.
- Dual destination: issue with register_wr_en (s3) and vector_wr_en (v4).
  - scalar_busy[3]=1, vector_busy[4]=1.
  - Separate retires clear each; idle=1 after both.
- Halt/flush: issue halt with s1 pending → halted=1, dec_ready stays 0.
  - Assert flush → busy all 0, halted still 1.
  - A spurious wb_s_en idx 9 afterwards sets sb_err=1.
- Reset mid-operation: rst_n low with several counters nonzero.
  - All outputs reach reset values immediately, without waiting for a clock edge.
